load_store_unit: RTL and testbench

Request/response front end between the RV32I execute stage and the word-wide data memory. Accepts one load or store per handshake and checks funct3 legality, address range and alignment. Drives the memory's word address, byte enables and replicated write data, then sign- or zero-extends load data. Returns a tagged response to writeback, with an error flag for faulting accesses.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store front end: request decode, byte-lane steering, load extension.
// Define MISALIGNED_TRAP_EN to fault misaligned accesses instead of aligning them.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  input  logic        req_write,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, WAIT, RESP
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        write_q;
  logic        err_q;

  logic        is_b, is_h, is_w;
  logic        f3_ok, range_err, mis, fault;
  logic        accept;
  logic [31:0] addr_a;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign is_b = (req_funct3[1:0] == 2'd0);
  assign is_h = (req_funct3[1:0] == 2'd1);
  assign is_w = (req_funct3[1:0] == 2'd2);

  always_comb begin
    f3_ok = 1'b0;
    if (req_write)
      f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1)
           || (req_funct3 == 3'd2);
    else
      f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1)
           || (req_funct3 == 3'd2) || (req_funct3 == 3'd4)
           || (req_funct3 == 3'd5);
  end

  assign range_err = (req_addr >= 32'(MEM_BYTES));
  assign mis = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));

`ifdef MISALIGNED_TRAP_EN
  assign fault = !f3_ok || range_err || mis;
`else
  assign fault = !f3_ok || range_err;
`endif

  // Force natural alignment; only matters when misaligned requests are performed.
  always_comb begin
    addr_a = req_addr;
    if (is_h) addr_a[0] = 1'b0;
    if (is_w) addr_a[1:0] = 2'b00;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    if (is_b) begin
      be_d    = 4'b0001 << addr_a[1:0];
      wdata_d = {4{req_wdata[7:0]}};
    end else if (is_h) begin
      be_d    = addr_a[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{req_wdata[15:0]}};
    end
  end

  assign ld_b = mem_rdata[8*off_q +: 8];
  assign ld_h = mem_rdata[16*off_q[1] +: 16];

  always_comb begin
    unique case (f3_q)
      3'd0:    data_d = {{24{ld_b[7]}}, ld_b};
      3'd4:    data_d = {24'd0, ld_b};
      3'd1:    data_d = {{16{ld_h[15]}}, ld_h};
      3'd5:    data_d = {16'd0, ld_h};
      default: data_d = mem_rdata;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = fault ? RESP : ACCESS;
      ACCESS:  state_d = write_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rd_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr_a[31:2];
        off_q   <= addr_a[1:0];
        be_q    <= be_d;
        wdata_q <= wdata_d;
        f3_q    <= req_funct3;
        rd_q    <= req_rd;
        write_q <= req_write;
        err_q   <= fault;
        data_q  <= '0;
      end
      if (state_q == WAIT) data_q <= data_d;
    end
  end

  // Strobes are gated by rst so a reset during ACCESS never touches memory.
  assign mem_we    = (state_q == ACCESS) && write_q && !rst;
  assign mem_re    = (state_q == ACCESS) && !write_q && !rst;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_rd    = rd_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide byte-enabled memory model.
// Expectations follow MISALIGNED_TRAP_EN when the bench is built with it.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_write = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:1023];
  int          nstrobe = 0;
  int          ncmp = 0;
  int          nerr = 0;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .req_write(req_write), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we),
    .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we || mem_re) nstrobe <= nstrobe + 1;
    if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; hold = cycles rsp_ready stays low once rsp_valid rises.
  task automatic xact(input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rd, input logic exp_err,
                      input logic [31:0] exp_data, input logic [29:0] exp_ma,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input int hold);
    int s0;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    s0 = nstrobe;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (exp_err) begin
      chk("strobe_none", 32'(mem_we | mem_re), 32'd0);
    end else begin
      chk("mem_we", 32'(mem_we), 32'(w));
      chk("mem_re", 32'(mem_re), 32'(!w));
      chk("mem_addr", 32'(mem_addr), 32'(exp_ma));
      chk("mem_be", 32'(mem_be), 32'(exp_be));
      if (w) chk("mem_wdata", mem_wdata, exp_wd);
      @(negedge clk);
      if (!w) begin
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
      end
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_rd", 32'(rsp_rd), 32'(rd));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_rd", 32'(rsp_rd), 32'(rd));
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
    if (exp_err) chk("no_strobe", nstrobe, s0);
    else chk("one_strobe", nstrobe, s0 + 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp", {rsp_data[26:0], rsp_rd} | 32'(rsp_err), 32'd0);
    rst = 1'b0;

    // w f3 addr wdata rd err data maddr be wdata hold
    xact(1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1, 0, 32'h0, 30'd4, 4'hF,
         32'hDEADBEEF, 0);
    xact(0, 3'd2, 32'h10, 32'h0, 5'd2, 0, 32'hDEADBEEF, 30'd4, 4'hF,
         32'h0, 0);
    xact(1, 3'd0, 32'h13, 32'h12345680, 5'd3, 0, 32'h0, 30'd4, 4'b1000,
         32'h80808080, 0);
    xact(0, 3'd0, 32'h13, 32'h0, 5'd4, 0, 32'hFFFFFF80, 30'd4, 4'b1000,
         32'h0, 0);
    xact(0, 3'd4, 32'h13, 32'h0, 5'd5, 0, 32'h00000080, 30'd4, 4'b1000,
         32'h0, 0);
    xact(1, 3'd1, 32'h22, 32'hABCD8001, 5'd6, 0, 32'h0, 30'd8, 4'b1100,
         32'h80018001, 0);
    xact(0, 3'd1, 32'h22, 32'h0, 5'd7, 0, 32'hFFFF8001, 30'd8, 4'b1100,
         32'h0, 0);
    xact(0, 3'd5, 32'h22, 32'h0, 5'd8, 0, 32'h00008001, 30'd8, 4'b1100,
         32'h0, 0);
    xact(0, 3'd0, 32'h10, 32'h0, 5'd0, 0, 32'hFFFFFFEF, 30'd4, 4'b0001,
         32'h0, 0);

`ifdef MISALIGNED_TRAP_EN
    xact(0, 3'd2, 32'h11, 32'h0, 5'd9, 1, 32'h0, 30'd0, 4'h0, 32'h0, 0);
    xact(0, 3'd1, 32'h23, 32'h0, 5'd10, 1, 32'h0, 30'd0, 4'h0, 32'h0, 0);
    xact(1, 3'd2, 32'h12, 32'h1, 5'd11, 1, 32'h0, 30'd0, 4'h0, 32'h0, 0);
`else
    xact(0, 3'd2, 32'h11, 32'h0, 5'd9, 0, 32'h80ADBEEF, 30'd4, 4'hF,
         32'h0, 0);
    xact(0, 3'd1, 32'h23, 32'h0, 5'd10, 0, 32'hFFFF8001, 30'd8, 4'b1100,
         32'h0, 0);
`endif

    xact(0, 3'd2, 32'h1000, 32'h0, 5'd12, 1, 32'h0, 30'd0, 4'h0, 32'h0, 0);
    xact(0, 3'd2, 32'hFFFFFFFC, 32'h0, 5'd13, 1, 32'h0, 30'd0, 4'h0,
         32'h0, 0);
    xact(0, 3'd3, 32'h0, 32'h0, 5'd14, 1, 32'h0, 30'd0, 4'h0, 32'h0, 0);
    xact(1, 3'd4, 32'h0, 32'hFF, 5'd15, 1, 32'h0, 30'd0, 4'h0, 32'h0, 0);

    xact(0, 3'd2, 32'h20, 32'h0, 5'd16, 0, 32'h80010000, 30'd8, 4'hF,
         32'h0, 5);

    // Reset lands on the ACCESS cycle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h30; req_wdata = 32'h12345678; req_rd = 5'd17;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_access_we", 32'(mem_we), 32'd0);
    chk("rst_access_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_drop_valid", 32'(rsp_valid), 32'd0);
    chk("rst_drop_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_model", mem[12], 32'h0);
    xact(0, 3'd2, 32'h30, 32'h0, 5'd18, 0, 32'h0, 30'd12, 4'hF, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
